arm_imm_encoder: RTL and testbench
==================================

Name: arm_imm_encoder

Overview:
- Inverse of the execute-stage Val2 immediate decode: takes a 32-bit constant and searches iteratively for the ARM data-processing immediate encoding {rotate[3:0], imm8[7:0]} with value == ror(imm8, 2*rotate).
- If no direct encoding exists, retries with ~value and flags the result as an MVN/inverted encoding.
- Sits beside the decode stage for the self-test/program-loader path, which converts constants into instruction words. Start/busy/done handshake.

Parameters:
CHECKS_PER_CYCLE, 1, rotations evaluated per search cycle; legal values 1, 2, 4, 8, 16.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-low.
start  input  1  request; accepted only while busy=0.
value  input  32  constant to encode; sampled on the accepting edge.
busy  output  1  search in progress.
done  output  1  one-cycle pulse; result outputs valid from this cycle.
found  output  1  encoding exists.
inverted  output  1  encoding applies to ~value (MVN form).
shift_operand  output  12  {rotate[3:0], imm8[7:0]}.

Behaviour:
- Reset: all outputs 0; state IDLE; internal value, step and phase registers cleared. Reset is asynchronous, so a mid-search reset aborts the search immediately with no done pulse.
- States: IDLE, SEARCH.
- IDLE, start=1:
  - Latch value.
  - step=0 (counts rotation groups), phase=0 (0 = value, 1 = ~value).
  - busy=1; go to SEARCH.
- IDLE, start=0: hold result outputs unchanged.
- SEARCH, candidate selection:
  - cand = phase ? ~latched : latched.
  - Evaluate rotations r = step*CPC .. step*CPC+CPC-1.
  - r matches when rol(cand, 2r)[31:8] == 0.
  - Lowest matching r wins.
- SEARCH, match found at the edge:
  - found=1, inverted=phase, shift_operand={r[3:0], rol(cand,2r)[7:0]}.
  - done=1, busy=0; go to IDLE.
- SEARCH, no match, last group (step == 16/CPC-1):
  - phase=0: phase=1, step=0; stay in SEARCH.
  - phase=1: found=0, inverted=0, shift_operand=0, done=1, busy=0; go to IDLE.
- SEARCH, no match, otherwise: step+1.
- Precedence and uniqueness:
  - The direct form always takes priority over the inverted form.
  - The lowest rotation always takes priority, so value=0 gives found=1, shift_operand=0x000, inverted=0.
- done is high for exactly one cycle. It is cleared on the next edge unless a new result completes on that edge.
- Latency, counted in edges after the accepting edge:
  - Direct match in group g completes on edge g+1.
  - Inverted match in group g completes on edge 16/CPC+g+1.
  - Failure completes on edge 2*16/CPC.
  - For CPC=1: best case 1, worst case 32.
- start while busy=1: ignored; the latched value is unchanged.
- start in the same cycle done=1: accepted, since busy=0. Result outputs hold until the next completion.
- Search arithmetic is pure 32-bit rotate; no carry or flag outputs.

Test Plan:
1. CPC=1, value=0x000000FF -> done after edge 1 post-accept; found=1, inverted=0, shift_operand=0x0FF.
2. CPC=1, value=0xFF000000 -> r=4, shift_operand=0x4FF, done at edge 5. Value=0x000003FC -> r=15, shift_operand=0xFFF, done at edge 16. Value=0xF000000F -> shift_operand=0x2FF.
3. CPC=1, value=0xFFFFFF00 -> direct search fails; inverted=1, found=1, shift_operand=0x0FF, done at edge 17.
4. CPC=1, value=0x00000101 -> found=0, inverted=0, shift_operand=0x000, done at edge 32, busy low afterwards.
5. Start at edge 3 of a search of 0xFF000000 with value=0x1 -> ignored; result still 0x4FF. Back-to-back start with done high -> accepted, busy=1 next cycle.
6. Pull rst low mid-search, then release -> outputs 0 immediately, no done pulse; a fresh start of 0xFF000000 with CPC=4 -> shift_operand=0x4FF at edge 2.

Source files
------------

// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder: iterative search for the ARM rotated-imm8 encoding of a 32-bit constant, falling back to the MVN (~value) form
module arm_imm_encoder #(
  parameter int CHECKS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        inverted,
  output logic [11:0] shift_operand
);
  localparam int GROUPS = 16 / CHECKS_PER_CYCLE;
  typedef enum logic {IDLE, SEARCH} state_t;
  state_t      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [3:0]  step_q, step_d;
  logic        phase_q, phase_d;
  logic        done_q, done_d;
  logic        found_q, found_d;
  logic        inverted_q, inverted_d;
  logic [11:0] so_q, so_d;
  logic [31:0] cand;
  logic [63:0] dbl;
  logic [3:0]  r;
  logic        hit;
  logic [3:0]  hit_r;
  logic [7:0]  hit_imm;
  // Walk the group from the top down so the lowest matching rotation is the one left standing.
  always_comb begin
    cand    = phase_q ? ~value_q : value_q;
    dbl     = '0;
    r       = '0;
    hit     = 1'b0;
    hit_r   = '0;
    hit_imm = '0;
    for (int k = CHECKS_PER_CYCLE - 1; k >= 0; k--) begin
      r   = 4'(int'(step_q) * CHECKS_PER_CYCLE + k);
      dbl = {cand, cand} << {r, 1'b0};
      if (dbl[63:40] == 24'd0) begin
        hit     = 1'b1;
        hit_r   = r;
        hit_imm = dbl[39:32];
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    step_d     = step_q;
    phase_d    = phase_q;
    done_d     = 1'b0;
    found_d    = found_q;
    inverted_d = inverted_q;
    so_d       = so_q;
    if (state_q == IDLE) begin
      if (start) begin
        value_d = value;
        step_d  = '0;
        phase_d = 1'b0;
        state_d = SEARCH;
      end
    end else if (hit) begin
      found_d    = 1'b1;
      inverted_d = phase_q;
      so_d       = {hit_r, hit_imm};
      done_d     = 1'b1;
      state_d    = IDLE;
    end else if (step_q == 4'(GROUPS - 1)) begin
      if (!phase_q) begin
        phase_d = 1'b1;
        step_d  = '0;
      end else begin
        found_d    = 1'b0;
        inverted_d = 1'b0;
        so_d       = '0;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
    end else begin
      step_d = step_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      value_q    <= '0;
      step_q     <= '0;
      phase_q    <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      inverted_q <= 1'b0;
      so_q       <= '0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      step_q     <= step_d;
      phase_q    <= phase_d;
      done_q     <= done_d;
      found_q    <= found_d;
      inverted_q <= inverted_d;
      so_q       <= so_d;
    end
  end
  assign busy          = (state_q == SEARCH);
  assign done          = done_q;
  assign found         = found_q;
  assign inverted      = inverted_q;
  assign shift_operand = so_q;
endmodule

// File: tb/tb_arm_imm_encoder.sv
// tb_arm_imm_encoder: directed vector table plus handshake/reset sequences for one-check and four-check encoders
module tb_arm_imm_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [31:0] value1 = '0, value2 = '0;
  logic        busy1, done1, found1, inv1, busy2, done2, found2, inv2;
  logic [11:0] so1, so2;
  logic        sel = 1'b0;
  logic        busy_s, done_s, found_s, inv_s;
  logic [11:0] so_s;
  int          total = 0, passed = 0;
  always #5 clk = ~clk;
  arm_imm_encoder #(.CHECKS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .value(value1), .busy(busy1), .done(done1),
    .found(found1), .inverted(inv1), .shift_operand(so1));
  arm_imm_encoder #(.CHECKS_PER_CYCLE(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .value(value2), .busy(busy2), .done(done2),
    .found(found2), .inverted(inv2), .shift_operand(so2));
  assign busy_s  = sel ? busy2 : busy1;
  assign done_s  = sel ? done2 : done1;
  assign found_s = sel ? found2 : found1;
  assign inv_s   = sel ? inv2 : inv1;
  assign so_s    = sel ? so2 : so1;
  typedef struct {
    logic [31:0] v;
    logic        f;
    logic        i;
    logic [11:0] so;
    int          lat;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic start_op(input logic [31:0] v);
    if (sel) begin start2 = 1'b1; value2 = v; end
    else begin start1 = 1'b1; value1 = v; end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (done_s) begin n = c; break; end
    end
  endtask
  task automatic check_result(input string tag, input vec_t e, input int n);
    chk({tag, " latency"}, 32'(n), 32'(e.lat));
    chk({tag, " found"}, 32'(found_s), 32'(e.f));
    chk({tag, " inverted"}, 32'(inv_s), 32'(e.i));
    chk({tag, " shift_operand"}, 32'(so_s), 32'(e.so));
    chk({tag, " busy at done"}, 32'(busy_s), 32'd0);
  endtask
  initial begin
    int n;
    vecs[0] = '{32'h000000FF, 1'b1, 1'b0, 12'h0FF, 1};
    vecs[1] = '{32'hFF000000, 1'b1, 1'b0, 12'h4FF, 5};
    vecs[2] = '{32'h000003FC, 1'b1, 1'b0, 12'hFFF, 16};
    vecs[3] = '{32'hF000000F, 1'b1, 1'b0, 12'h2FF, 3};
    vecs[4] = '{32'hFFFFFF00, 1'b1, 1'b1, 12'h0FF, 17};
    vecs[5] = '{32'h00000101, 1'b0, 1'b0, 12'h000, 32};
    vecs[6] = '{32'h00000000, 1'b1, 1'b0, 12'h000, 1};
    vecs[7] = '{32'hFFFFFFFF, 1'b1, 1'b1, 12'h000, 17};
    vecs[8] = '{32'h00000104, 1'b1, 1'b0, 12'hF41, 16};
    vecs[9] = '{32'h00AB0000, 1'b1, 1'b0, 12'h8AB, 9};
    #12;
    chk("reset busy", 32'(busy1), 32'd0);
    chk("reset done", 32'(done1), 32'd0);
    chk("reset found", 32'(found1), 32'd0);
    chk("reset so", 32'(so1), 32'd0);
    chk("reset so cpc4", 32'(so2), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 0; t < 10; t++) begin
      start_op(vecs[t].v);
      chk($sformatf("v%0d busy after accept", t), 32'(busy_s), 32'd1);
      wait_done(n);
      check_result($sformatf("v%0d", t), vecs[t], n);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done pulse width", t), 32'(done_s), 32'd0);
    end
    // start while busy is ignored; start alongside done is accepted
    start_op(32'hFF000000);
    @(posedge clk);
    #1;
    start1 = 1'b1;
    value1 = 32'h1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_done(n);
    check_result("ignore start", '{32'hFF000000, 1'b1, 1'b0, 12'h4FF, 3}, n);
    start_op(32'h000000FF);
    chk("b2b busy", 32'(busy1), 32'd1);
    chk("b2b done cleared", 32'(done1), 32'd0);
    chk("b2b result held", 32'(so1), 32'h4FF);
    wait_done(n);
    check_result("b2b", '{32'h000000FF, 1'b1, 1'b0, 12'h0FF, 1}, n);
    // asynchronous reset mid-search
    start_op(32'h00000101);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst busy", 32'(busy1), 32'd0);
    chk("arst found", 32'(found1), 32'd0);
    chk("arst so", 32'(so1), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("arst no done", 32'(done1), 32'd0);
    end
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done1 || busy1) begin
        chk("post-reset idle", 32'(done1 | busy1), 32'd0);
        break;
      end
    end
    sel = 1'b1;
    start_op(32'hFF000000);
    wait_done(n);
    check_result("cpc4", '{32'hFF000000, 1'b1, 1'b0, 12'h4FF, 2}, n);
    start_op(32'hFFFFFF00);
    wait_done(n);
    check_result("cpc4 inv", '{32'hFFFFFF00, 1'b1, 1'b1, 12'h0FF, 5}, n);
    start_op(32'h00000101);
    wait_done(n);
    check_result("cpc4 fail", '{32'h00000101, 1'b0, 1'b0, 12'h000, 8}, n);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
